sdp_ram_param: RTL

Parametrised simple-dual-port block-RAM model: write-only port A, read-only port B with a registered output. It generalises the fixed 36x1024 on-chip memory to configurable width and depth. It adds per-byte write enables and a selectable read-during-write collision mode. A post-reset clear sequencer initialises every location, and a read-valid strobe marks returned data. It sits beside the BRAM primitive models as the golden reference for TDP/SDP mapping benches.

---
 rtl/sdp_ram_param.sv | 186 ++++++++++++++++++
 1 files changed

// File: rtl/sdp_ram_param.sv
// rtl/sdp_ram_param.sv - parametrised simple-dual-port RAM with byte enables and clear sequencer
//
// Purpose:
//   Write-only port A, read-only port B with registered output. After reset a
//   clear sequencer writes INIT_VALUE to every location (busy high), then the
//   array accepts user traffic (init_done high). Same-address read-during-write
//   returns the merged word (RDW_MODE=0, write-first) or the old word
//   (RDW_MODE=1, read-first).
//   Optional feature macro: SDP_RAM_OUT_REG_EN adds a second output register
//   stage (read latency 2 instead of 1).
//
// Ports:
//   clk        - sole clock, rising edge
//   rst        - asynchronous active-low reset
//   wen_A      - port A write request
//   be_A       - byte-lane enables, bit k covers din_A[k*BYTE_WIDTH +: BYTE_WIDTH]
//   addr_A     - write address
//   din_A      - write data
//   ren_B      - port B read request
//   addr_B     - read address
//   dout_B     - read data, holds while no read completes
//   dout_vld_B - one-cycle strobe marking a new read result on dout_B
//   busy       - high while the clear sequencer runs
//   init_done  - high once the array has been initialised

module sdp_ram_param #(
  parameter int                    DATA_WIDTH = 36,
  parameter int                    ADDR_WIDTH = 10,
  parameter int                    BYTE_WIDTH = 9,
  parameter int                    RDW_MODE   = 0,
  parameter logic [DATA_WIDTH-1:0] INIT_VALUE = '0
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             wen_A,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] be_A,
  input  logic [ADDR_WIDTH-1:0]            addr_A,
  input  logic [DATA_WIDTH-1:0]            din_A,
  input  logic                             ren_B,
  input  logic [ADDR_WIDTH-1:0]            addr_B,
  output logic [DATA_WIDTH-1:0]            dout_B,
  output logic                             dout_vld_B,
  output logic                             busy,
  output logic                             init_done
);

  localparam int DEPTH  = 1 << ADDR_WIDTH;
  localparam int NUM_BE = DATA_WIDTH / BYTE_WIDTH;

  typedef enum logic {
    CLEAR = 1'b0,
    READY = 1'b1
  } state_t;

  state_t                  state_q, state_d;
  logic [ADDR_WIDTH-1:0]   cnt_q, cnt_d;
  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];

  logic                    wr_en;
  logic [ADDR_WIDTH-1:0]   wr_addr;
  logic [DATA_WIDTH-1:0]   wr_data;
  logic [NUM_BE-1:0]       wr_be;

  logic [DATA_WIDTH-1:0]   rd_old;
  logic [DATA_WIDTH-1:0]   rd_merged;
  logic [DATA_WIDTH-1:0]   dout_q, dout_d;
  logic                    vld_q, vld_d;

  // Control FSM: state and clear counter
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= CLEAR;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    busy      = 1'b0;
    init_done = 1'b0;
    wr_en     = 1'b0;
    wr_addr   = addr_A;
    wr_data   = din_A;
    wr_be     = be_A;
    vld_d     = 1'b0;
    case (state_q)
      CLEAR: begin
        busy    = 1'b1;
        // User requests are ignored; the sequencer owns the write port.
        wr_en   = 1'b1;
        wr_addr = cnt_q;
        wr_data = INIT_VALUE;
        wr_be   = '1;
        cnt_d   = cnt_q + ADDR_WIDTH'(1);
        if (cnt_q == {ADDR_WIDTH{1'b1}}) begin
          state_d = READY;
        end
      end
      READY: begin
        init_done = 1'b1;
        wr_en     = wen_A;
        vld_d     = ren_B;
      end
      default: begin
        state_d = CLEAR;
        cnt_d   = '0;
      end
    endcase
  end

  // Array write; lanes with a cleared enable keep their old contents.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      for (int k = 0; k < NUM_BE; k++) begin
        if (wr_be[k]) begin
          mem_q[wr_addr][k*BYTE_WIDTH +: BYTE_WIDTH] <= wr_data[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Write-first view of the read word: enabled lanes of a same-address write
  // bypass the array so the reader sees the data landing on this edge.
  always_comb begin
    rd_old    = mem_q[addr_B];
    rd_merged = rd_old;
    if (wen_A && (addr_A == addr_B)) begin
      for (int k = 0; k < NUM_BE; k++) begin
        if (be_A[k]) begin
          rd_merged[k*BYTE_WIDTH +: BYTE_WIDTH] = din_A[k*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  always_comb begin
    dout_d = dout_q;
    if (vld_d) begin
      dout_d = (RDW_MODE == 0) ? rd_merged : rd_old;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      dout_q <= dout_d;
      vld_q  <= vld_d;
    end
  end

`ifdef SDP_RAM_OUT_REG_EN
  logic [DATA_WIDTH-1:0] dout2_q, dout2_d;
  logic                  vld2_q;

  // Stage 2 only advances when stage 1 holds a fresh result.
  always_comb begin
    dout2_d = dout2_q;
    if (vld_q) begin
      dout2_d = dout_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout2_q <= '0;
      vld2_q  <= 1'b0;
    end else begin
      dout2_q <= dout2_d;
      vld2_q  <= vld_q;
    end
  end

  assign dout_B     = dout2_q;
  assign dout_vld_B = vld2_q;
`else
  assign dout_B     = dout_q;
  assign dout_vld_B = vld_q;
`endif

endmodule
